rr_arbiter8: RTL and testbench
==============================

# rr_arbiter8

Round-robin arbiter that shares one downstream resource between eight requesters and issues a registered one-hot grant. The fairness search is a rotated 8-to-3 priority encode over the request vector, so the highest-priority active requester moves after every grant. It sits between the requesting agents and the shared datapath (bus port, encoder or memory port) and drives that resource's select lines from `gnt_id`.

## Interface
- `MAX_HOLD`, default 16: maximum cycles a grant may be held before forced release. Range is 1..255. Used only when `ARB_TIMEOUT_EN` is defined.
- `clk`  in  1  single clock; all logic rising-edge.
- `rst`  in  1  reset is synchronous and active-high.
- `req`  in  8  request vector; bit i = requester i.
- `done`  in  1  owner releases the resource (qualified only in GRANT).
- `gnt`  out  8  one-hot grant, registered.
- `gnt_id`  out  3  binary index of the granted requester, registered.
- `gnt_valid`  out  1  high while a grant is held.
- `timeout`  out  1  one-cycle pulse on forced release.

## Operation
- The FSM has two states, IDLE and GRANT.
- A 3-bit pointer `ptr` names the highest-priority requester for the next arbitration.
- **Reset** (`rst` high at an edge): state=IDLE, `ptr`=0, `gnt`=8'h00, `gnt_id`=3'b000, `gnt_valid`=0, `timeout`=0, hold counter=0. Reset wins over every other event, including mid-grant.
- **IDLE, `req`==0:** stay in IDLE; outputs stay at their reset values.
- **IDLE, `req`!=0:**
  - Select k = first set bit searching `ptr`, `ptr`+1, ... modulo 8.
  - Go to GRANT with `gnt`=1<<k, `gnt_id`=k, `gnt_valid`=1.
  - Set `ptr`=(k+1) mod 8; wrap-around from k=7 gives `ptr`=0.
  - Clear the hold counter.
- **GRANT:** `gnt` and `gnt_id` stay stable. Changes to other `req` bits are ignored.
- **Release conditions**, any one of which applies at the current edge:
  - `done`=1;
  - `req[gnt_id]`=0 (owner withdrew);
  - timeout (see Configuration).
- **On release:** go to IDLE, `gnt`=0, `gnt_valid`=0. `gnt_id` holds its last value.
- **Simultaneous release causes:** the result is one release. `timeout` pulses only if neither `done` nor the request drop is present.
- `done` is ignored in IDLE.
- Invariant: `gnt` is 0 or one-hot, and `gnt_valid` equals |`gnt`.

## Timing
- **Grant latency:** `req` sampled at edge N in IDLE gives `gnt` valid from edge N through the next release. Latency is 1 cycle from request to visible grant.
- **Release:** a condition sampled at edge M deasserts `gnt` after edge M.
- **Re-arbitration:** the earliest next grant is at edge M+1. There is always exactly one dead cycle between grants.
- **Minimum grant length:** 1 cycle, when `done` is high in the first GRANT cycle.
- **Back-to-back fairness:** with all 8 requesters continuously active and releasing via `done`, grants go 0,1,...,7,0 with one IDLE cycle between each.
- **`timeout`:** registered, high for exactly the one cycle following the forcing edge (coincident with the IDLE cycle).

## Configuration
- Macro: `ARB_TIMEOUT_EN`.
- **Defined:**
  - Add an 8-bit hold counter that increments each GRANT cycle without release.
  - When the counter equals `MAX_HOLD`-1 at an edge, force release.
  - The grant therefore lasts at most `MAX_HOLD` cycles, and `timeout` pulses.
  - With `MAX_HOLD`=1 every grant is exactly 1 cycle.
- **Undefined:**
  - No counter is built and `MAX_HOLD` is unused.
  - `timeout` is tied 0.
  - A grant is held until `done` or the owner's request drops; it may last indefinitely.

## Test plan
- **Reset mid-grant:** grant requester 5, then assert `rst` for 1 cycle -> next cycle `gnt`=0, `gnt_valid`=0, `gnt_id`=0. A following `req`=8'hFF grants requester 0 (`ptr`=0).
- **Round-robin wrap:** hold `req`=8'hFF and pulse `done` in each grant's first cycle -> `gnt_id` sequence 0,1,...,7,0,1. `gnt` is one-hot with one IDLE gap each time.
- **Skipping idle requesters:** `ptr`=0, `req`=8'b1000_0100 -> grant 2. After release grant 7. After release grant 2 again (pointer wrapped to 0).
- **Owner withdrawal:** grant 3, then drop `req[3]` while `done`=0 -> `gnt` deasserts 1 cycle later, `timeout`=0. The next requester above 3 is granted after the dead cycle.
- **Timeout** (`ARB_TIMEOUT_EN`, `MAX_HOLD`=4): `req`=8'h01, `done`=0 -> `gnt`=8'h01 for exactly 4 cycles, then `timeout`=1 for 1 cycle. Re-grant to 0 follows. Without the macro, `gnt` stays 8'h01 for 100+ cycles and `timeout` stays 0.
- **Simultaneous `done` and timeout** (`MAX_HOLD`=4, `done` in 4th cycle) -> a single release with `timeout`=0.

Source files
------------

// File: rtl/rr_arbiter8.sv
// Purpose : eight-way round-robin arbiter with a registered one-hot grant and binary grant index.
// Latency : the grant is visible after the edge that samples the request; there is one dead IDLE cycle between grants.
// Backpres: the owner holds the grant until done, its request drops, or (with ARB_TIMEOUT_EN) MAX_HOLD cycles pass.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     state_q;
  state_t     state_d;
  logic [2:0] ptr;
  logic       pick_vld;
  logic [2:0] pick_id;
  logic       release_user;
  logic       release_any;

  // Catch an out-of-range hold limit when the design is elaborated.
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter8: MAX_HOLD must be in 1..255");
  end

  // Rotated priority search: first set request at ptr, ptr+1, ... modulo 8.
  always_comb begin
    logic [2:0] idx;
    pick_vld = 1'b0;
    pick_id  = ptr;
    idx      = ptr;
    // Walk from the farthest offset down so the closest match is written last.
    for (int i = 7; i >= 0; i--) begin
      idx = ptr + 3'(i);
      if (req[idx]) begin
        pick_vld = 1'b1;
        pick_id  = idx;
      end
    end
  end

  // Owner-driven release: explicit done or withdrawal of the owner's request.
  assign release_user = done | ~req[gnt_id];

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;
  logic       hold_hit;

  assign hold_hit    = (hold_cnt == 8'(MAX_HOLD - 1));
  assign release_any = release_user | hold_hit;

  // Hold counter cleared on every new grant; timeout only when the limit alone forced release.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= 8'd0;
      timeout  <= 1'b0;
    end else begin
      timeout <= (state_q == GRANT) & hold_hit & ~release_user;
      if (state_q == IDLE) begin
        if (pick_vld) hold_cnt <= 8'd0;
      end else if (!release_any) begin
        hold_cnt <= hold_cnt + 8'd1;
      end
    end
  end
`else
  assign release_any = release_user;
  assign timeout     = 1'b0;
`endif

  // State register plus registered grant, index and fairness pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr     <= 3'd0;
      gnt     <= 8'h00;
      gnt_id  <= 3'd0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        if (pick_vld) begin
          gnt    <= 8'b1 << pick_id;
          gnt_id <= pick_id;
          ptr    <= pick_id + 3'd1;
        end
      end else if (release_any) begin
        gnt <= 8'h00;
      end
    end
  end

  // Next-state: leave IDLE on any request, leave GRANT on any release cause.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_vld)    state_d = GRANT;
      GRANT:   if (release_any) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs derived from state: a grant is held exactly while in GRANT.
  always_comb begin
    gnt_valid = (state_q == GRANT);
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8 with hand-computed expected grants.
// Runs with MAX_HOLD=4; timeout checks depend on whether ARB_TIMEOUT_EN is defined.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int n_tests = 0;
  int n_fail  = 0;

  rr_arbiter8 #(.MAX_HOLD(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_gnt(input string tag, input logic [7:0] eg, input logic [2:0] eid, input logic ev);
    check({tag, ".gnt"}, 32'(gnt), 32'(eg));
    check({tag, ".gnt_id"}, 32'(gnt_id), 32'(eid));
    check({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(ev));
  endtask

  initial begin
    logic [7:0] exp_g;
    rst  = 1'b1;
    req  = 8'h00;
    done = 1'b0;
    step();
    chk_gnt("reset", 8'h00, 3'd0, 1'b0);
    check("reset.timeout", 32'(timeout), 32'd0);

    // Idle with no request, done ignored
    rst  = 1'b0;
    done = 1'b1;
    step();
    chk_gnt("idle_done", 8'h00, 3'd0, 1'b0);

    // Round-robin wrap: all requesting, done in each grant's first cycle
    req = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      step();
      exp_g = 8'h01 << (i % 8);
      chk_gnt($sformatf("rr_grant%0d", i), exp_g, 3'(i % 8), 1'b1);
      step();
      chk_gnt($sformatf("rr_gap%0d", i), 8'h00, 3'(i % 8), 1'b0);
    end

    // Reset mid-grant (ptr is 2 here, only requester 5 asks)
    req  = 8'h20;
    done = 1'b0;
    step();
    chk_gnt("grant5", 8'h20, 3'd5, 1'b1);
    rst = 1'b1;
    step();
    chk_gnt("rst_mid", 8'h00, 3'd0, 1'b0);
    rst = 1'b0;
    req = 8'hFF;
    step();
    chk_gnt("post_rst_grant0", 8'h01, 3'd0, 1'b1);
    req  = 8'h00;
    done = 1'b1;
    step();
    chk_gnt("post_rst_rel", 8'h00, 3'd0, 1'b0);
    check("post_rst_rel.timeout", 32'(timeout), 32'd0);

    // Skipping idle requesters from ptr=0
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 8'b1000_0100;
    step();
    chk_gnt("skip_a", 8'h04, 3'd2, 1'b1);
    step();
    chk_gnt("skip_a_rel", 8'h00, 3'd2, 1'b0);
    step();
    chk_gnt("skip_b", 8'h80, 3'd7, 1'b1);
    step();
    step();
    chk_gnt("skip_c", 8'h04, 3'd2, 1'b1);
    step();
    chk_gnt("skip_c_rel", 8'h00, 3'd2, 1'b0);

    // Owner withdrawal
    rst = 1'b1;
    step();
    rst  = 1'b0;
    done = 1'b0;
    req  = 8'b0101_1000;
    step();
    chk_gnt("wd_grant3", 8'h08, 3'd3, 1'b1);
    req = 8'b0101_1001;
    step();
    chk_gnt("wd_hold", 8'h08, 3'd3, 1'b1);
    req = 8'b0101_0001;
    step();
    chk_gnt("wd_rel", 8'h00, 3'd3, 1'b0);
    check("wd_rel.timeout", 32'(timeout), 32'd0);
    step();
    chk_gnt("wd_next4", 8'h10, 3'd4, 1'b1);
    done = 1'b1;
    req  = 8'h00;
    step();
    chk_gnt("wd_next4_rel", 8'h00, 3'd4, 1'b0);

    // Hold / timeout behaviour with requester 0 alone
    rst = 1'b1;
    step();
    rst  = 1'b0;
    done = 1'b0;
    req  = 8'h01;
    step();
    chk_gnt("to_grant", 8'h01, 3'd0, 1'b1);
`ifdef ARB_TIMEOUT_EN
    for (int i = 1; i < 4; i++) begin
      step();
      chk_gnt($sformatf("to_hold%0d", i), 8'h01, 3'd0, 1'b1);
      check($sformatf("to_hold%0d.timeout", i), 32'(timeout), 32'd0);
    end
    step();
    chk_gnt("to_forced", 8'h00, 3'd0, 1'b0);
    check("to_forced.timeout", 32'(timeout), 32'd1);
    step();
    chk_gnt("to_regrant", 8'h01, 3'd0, 1'b1);
    check("to_regrant.timeout", 32'(timeout), 32'd0);
    for (int i = 1; i < 4; i++) begin
      step();
      chk_gnt($sformatf("sim_hold%0d", i), 8'h01, 3'd0, 1'b1);
    end
    done = 1'b1;
    step();
    chk_gnt("sim_rel", 8'h00, 3'd0, 1'b0);
    check("sim_rel.timeout", 32'(timeout), 32'd0);
`else
    for (int i = 1; i <= 110; i++) begin
      step();
      check($sformatf("hold%0d.gnt", i), 32'(gnt), 32'h01);
      check($sformatf("hold%0d.timeout", i), 32'(timeout), 32'd0);
    end
    done = 1'b1;
    step();
    chk_gnt("hold_rel", 8'h00, 3'd0, 1'b0);
    check("hold_rel.timeout", 32'(timeout), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
